// File: rtl/pes_fb_sipo_rx.sv
`default_nettype none
// ============================================================================
//  Module   : pes_fb_sipo_rx
//  Purpose  : LSB-first serial-to-parallel receiver with valid/ready output,
//             sticky abort/overrun flags and a wrapping frame counter.
//  Revision : 1.0  initial release
// ============================================================================
module pes_fb_sipo_rx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    input  logic             err_clr,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int              BC_W       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BC_W-1:0] c_LAST_IDX = BC_W'(WIDTH - 1);
    localparam logic [BC_W-1:0] c_BC_ONE   = BC_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shreg;
    logic [BC_W-1:0]  r_bitcnt;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic [CNT_W-1:0] r_frame_cnt;

    logic w_restart;
    logic w_capture;
    logic w_abort;
    logic w_complete;
    logic w_out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_restart    = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (start) begin
                    w_restart = 1'b1;
                    w_abort   = 1'b1;
                end else begin
                    w_capture = 1'b1;
                    if (r_bitcnt == c_LAST_IDX) begin
                        w_complete   = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A slot is free if empty, or being drained by the consumer this cycle.
    assign w_out_free = !r_out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else if (w_restart) begin
            r_shreg[0] <= sin;
            r_bitcnt   <= c_BC_ONE;
        end else if (w_capture) begin
            r_shreg[r_bitcnt] <= sin;
            r_bitcnt          <= w_complete ? '0 : (r_bitcnt + c_BC_ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_frame_cnt <= '0;
        end else if (w_complete && w_out_free) begin
            r_out_data  <= {sin, r_shreg[WIDTH-2:0]};
            r_out_valid <= 1'b1;
            r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Set events take priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_abort) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
            if (w_complete && !w_out_free) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == SHIFT);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
